// File: rtl/ah_rr_mux.sv
// ah_rr_mux: N-to-1 round-robin valid/ready mux with a registered egress stage carrying the source index.
// Define AH_RR_MUX_FIXED_PRIO_EN for strict fixed priority (lowest index wins, no pointer).
module ah_rr_mux #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int SW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*DW-1:0] ing_data,
  input  logic [N-1:0]    ing_valid,
  output logic [N-1:0]    ing_ready,
  output logic [DW-1:0]   egr_data,
  output logic            egr_valid,
  input  logic            egr_ready,
  output logic [SW-1:0]   egr_src
);
  logic [DW-1:0] ing_arr [N];
  logic [DW-1:0] egr_data_q;
  logic [SW-1:0] egr_src_q, base, gidx;
  logic [SW:0]   sum;
  logic [N-1:0]  gnt;
  logic          egr_valid_q, egr_valid_d, found, load_en, take;
  for (genvar i = 0; i < N; i++) begin : g_split
    assign ing_arr[i] = ing_data[i*DW +: DW];
  end
`ifdef AH_RR_MUX_FIXED_PRIO_EN
  assign base = SW'(N-1);
`else
  logic [SW-1:0] ptr_q, ptr_d;
  assign base  = ptr_q;
  assign ptr_d = take ? gidx : ptr_q;
  always_ff @(posedge clk) ptr_q <= !rst_n ? SW'(N-1) : ptr_d;
`endif
  // search starts one past base and wraps explicitly at N so non-power-of-2 sizes never grant index >= N
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, base} + (SW+1)'(k);
      sum = (sum >= (SW+1)'(N)) ? sum - (SW+1)'(N) : sum;
      if (!found && ing_valid[sum[SW-1:0]]) begin
        found              = 1'b1;
        gnt[sum[SW-1:0]]   = 1'b1;
        gidx               = sum[SW-1:0];
      end
    end
  end
  assign load_en     = ~egr_valid_q | egr_ready;
  assign ing_ready   = (rst_n & load_en) ? gnt : '0;
  assign take        = |ing_ready;
  assign egr_valid_d = take | (egr_valid_q & ~egr_ready);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      egr_valid_q <= 1'b0;
      egr_data_q  <= '0;
      egr_src_q   <= '0;
    end else begin
      egr_valid_q <= egr_valid_d;
      egr_data_q  <= take ? ing_arr[gidx] : egr_data_q;
      egr_src_q   <= take ? gidx : egr_src_q;
    end
  end
  assign egr_valid = egr_valid_q;
  assign egr_data  = egr_data_q;
  assign egr_src   = egr_src_q;
endmodule

// File: tb/tb_ah_rr_mux.sv
// tb_ah_rr_mux: scoreboard bench for ah_rr_mux; directed test-plan cases then randomized traffic.
module tb_ah_rr_mux;
  localparam int N = 4, DW = 8, SW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N*DW-1:0] ing_data;
  logic [N-1:0]    ing_valid, ing_ready, acc = '0;
  logic [DW-1:0]   egr_data;
  logic            egr_valid, egr_ready;
  logic [SW-1:0]   egr_src;
  bit              rst_seen = 1'b1, m_full = 1'b0;
  int              vecs = 0, errs = 0, m_ptr = N-1;
  typedef struct { int src; logic [DW-1:0] d; } beat_t;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  ah_rr_mux #(.N(N), .DW(DW), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .ing_data(ing_data), .ing_valid(ing_valid),
    .ing_ready(ing_ready), .egr_data(egr_data), .egr_valid(egr_valid),
    .egr_ready(egr_ready), .egr_src(egr_src));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // first valid port at or after (p+1) mod N; fixed-priority build always starts at 0
  function automatic int pick(logic [N-1:0] v, int p);
`ifdef AH_RR_MUX_FIXED_PRIO_EN
    p = N-1;
`endif
    for (int k = 1; k <= N; k++)
      if (v[(p+k)%N]) return (p+k)%N;
    return -1;
  endfunction

  always @(posedge clk) rst_seen <= !rst_n;

  // reference model: predicts ready, egress occupancy, and queues the expected beat on every handshake
  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    if (rst_seen) begin
      chk("rst_egr_valid", egr_valid, 0);
      chk("rst_egr_data", egr_data, 0);
      chk("rst_egr_src", egr_src, 0);
    end
    if (!rst_n) begin
      chk("rst_ing_ready", ing_ready, 0);
      m_ptr = N-1;
      m_full = 1'b0;
      exp_q.delete();
      acc = '0;
    end else begin
      g  = (!m_full || egr_ready) ? pick(ing_valid, m_ptr) : -1;
      er = (g >= 0) ? (N'(1) << g) : '0;
      chk("ing_ready", ing_ready, er);
      chk("egr_valid", egr_valid, m_full);
      acc = ing_ready & ing_valid;
      if (g >= 0) begin
        exp_q.push_back('{g, ing_data[g*DW +: DW]});
        m_ptr  = g;
        m_full = 1'b1;
      end else if (egr_ready) m_full = 1'b0;
    end
  end

  always @(negedge clk) begin
    beat_t b;
    if (rst_n && egr_valid && egr_ready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        b = exp_q.pop_front();
        chk("egr_src", egr_src, b.src);
        chk("egr_data", egr_data, b.d);
      end
    end
  end

  task automatic drive(logic [N-1:0] v, logic r);
    @(posedge clk); #1;
    ing_valid = v;
    egr_ready = r;
  endtask

  initial begin
    int s;
    ing_valid = '1;
    egr_ready = 1'b1;
    ing_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk) chk("first_grant", ing_ready, 4'b0001);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
`ifdef AH_RR_MUX_FIXED_PRIO_EN
      s = 0;
`else
      s = j % N;
`endif
      chk("rot_src", egr_src, s);
      chk("rot_data", egr_data, 8'h10 + s);
    end
    drive(4'b0100, 1'b1);
    ing_data[23:16] = 8'hA5;
    @(negedge clk) chk("single_ready", ing_ready, 4'b0100);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    chk("single_valid", egr_valid, 1);
    chk("single_data", egr_data, 8'hA5);
    chk("single_src", egr_src, 2);
    ing_data = {8'h53, 8'h52, 8'h51, 8'h50};
    drive(4'b0010, 1'b1);
    @(negedge clk) chk("bp_load", ing_ready, 4'b0010);
    drive(4'b1001, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", ing_ready, 0);
      chk("bp_data", egr_data, 8'h51);
      chk("bp_src", egr_src, 1);
      @(posedge clk); #1;
    end
    egr_ready = 1'b1;
`ifdef AH_RR_MUX_FIXED_PRIO_EN
    @(negedge clk) chk("bp_release", ing_ready, 4'b0001);
`else
    @(negedge clk) chk("bp_release", ing_ready, 4'b1000);
`endif
    drive(4'b1010, 1'b1);
`ifdef AH_RR_MUX_FIXED_PRIO_EN
    @(negedge clk);
`else
    @(negedge clk) chk("gap_first", ing_ready, 4'b0010);
`endif
    drive(4'b1000, 1'b1);
    @(negedge clk) chk("gap_second", ing_ready, 4'b1000);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    chk("gap_src", egr_src, 3);
    chk("gap_valid", egr_valid, 1);
    @(negedge clk) chk("gap_drain", egr_valid, 0);
    drive(4'b1111, 1'b0);
    @(negedge clk) chk("gap_ptr", ing_ready, 4'b0001);
    @(negedge clk) chk("mid_valid", egr_valid, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", egr_valid, 0);
    chk("mid_rst_grant", ing_ready, 4'b0001);
    repeat (3000) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (!(ing_valid[i] && !acc[i])) begin
          ing_valid[i] = ($urandom_range(0, 2) != 0);
          ing_data[i*DW +: DW] = DW'($urandom);
        end
      egr_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ing_valid = '0;
    egr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
